// File: rtl/elevator_goal_scheduler.sv
// SCAN goal-floor scheduler: latches requests, picks goals, times door service.
// Optional intermediate-stop retargeting: ELEVATOR_COLLECTIVE_EN.
module elevator_goal_scheduler #(
  parameter int FLOORS = 3,
  parameter int FW     = 2,
  parameter int DWELL  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FW-1:0]     floor,
  input  logic              moving,
  input  logic [FLOORS-1:0] req,
  output logic [FLOORS-1:0] pending,
  output logic [FW-1:0]     gf,
  output logic              gf_valid,
  output logic              dir_up,
  output logic              door_open
);

`ifdef ELEVATOR_COLLECTIVE_EN
  localparam bit COLLECTIVE = 1'b1;
`else
  localparam bit COLLECTIVE = 1'b0;
`endif

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    SERVE = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [FLOORS-1:0] pending_n;
  logic [FW-1:0]     gf_n;
  logic              dir_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [FW-1:0]     sfl, sfl_n;

  logic [FW-1:0] pos;
  logic          pos_ok;
  logic [FW-1:0] near, abv, blw;
  logic          abv_ok, blw_ok;
  logic          go_up, go_dn;
  int            fl, d, best;

  // In SERVE the search is anchored at the floor being served.
  assign pos    = (state == SERVE) ? sfl : floor;
  assign pos_ok = int'(floor) < FLOORS;

  always_comb begin
    near   = '0;
    abv    = '0;
    blw    = '0;
    abv_ok = 1'b0;
    blw_ok = 1'b0;
    fl     = int'(pos);
    d      = 0;
    best   = FLOORS;
    for (int k = 0; k < FLOORS; k++) begin
      if (pending[k]) begin
        d = (k > fl) ? k - fl : fl - k;
        if (d < best) begin
          best = d;
          near = FW'(k);
        end
        if (k > fl && !abv_ok) begin
          abv    = FW'(k);
          abv_ok = 1'b1;
        end
        if (k < fl) begin
          blw    = FW'(k);
          blw_ok = 1'b1;
        end
      end
    end
  end

  assign go_up = dir_up ? abv_ok : (abv_ok && !blw_ok);
  assign go_dn = dir_up ? (blw_ok && !abv_ok) : blw_ok;

  always_comb begin
    pending_n = pending | req;
    if (state == SERVE) pending_n[sfl] = 1'b0;
  end

  always_comb begin
    state_n = state;
    gf_n    = gf;
    dir_n   = dir_up;
    cnt_n   = cnt;
    sfl_n   = sfl;
    if (pos_ok) begin
      unique case (state)
        IDLE: begin
          if (!moving && pending != '0) begin
            if (pending[floor]) begin
              state_n = SERVE;
              sfl_n   = floor;
              cnt_n   = '0;
            end else begin
              gf_n    = near;
              dir_n   = near > floor;
              state_n = (near > floor) ? UP : DOWN;
            end
          end
        end
        UP, DOWN: begin
          if (!moving && floor == gf) begin
            state_n = SERVE;
            sfl_n   = floor;
            cnt_n   = '0;
          end else if (COLLECTIVE && state == UP && abv_ok && abv < gf) begin
            gf_n = abv;
          end else if (COLLECTIVE && state == DOWN && blw_ok && blw > gf) begin
            gf_n = blw;
          end
        end
        SERVE: begin
          if (cnt == LAST) begin
            unique case (1'b1)
              go_up: begin
                gf_n    = abv;
                dir_n   = 1'b1;
                state_n = UP;
              end
              go_dn: begin
                gf_n    = blw;
                dir_n   = 1'b0;
                state_n = DOWN;
              end
              default: state_n = IDLE;
            endcase
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      gf        <= '0;
      gf_valid  <= 1'b0;
      dir_up    <= 1'b1;
      door_open <= 1'b0;
      cnt       <= '0;
      sfl       <= '0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      gf        <= gf_n;
      gf_valid  <= (state_n == UP) || (state_n == DOWN);
      dir_up    <= dir_n;
      door_open <= state_n == SERVE;
      cnt       <= cnt_n;
      sfl       <= sfl_n;
    end
  end

endmodule

// File: tb/tb_elevator_goal_scheduler.sv
// Scoreboard bench: three scheduler instances (3, 5 and 8 floors).
// Expected outputs are queued per cycle and checked by a negedge monitor.
module tb_elevator_goal_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] fa;
  logic       mva;
  logic [2:0] rqa, pa;
  logic [1:0] ga;
  logic       gva, dua, dopa;

  logic [2:0] fb;
  logic       mvb;
  logic [4:0] rqb, pb;
  logic [2:0] gb;
  logic       gvb, dub, dopb;

  logic [2:0] fc;
  logic       mvc;
  logic [7:0] rqc, pc;
  logic [2:0] gc;
  logic       gvc, duc, dopc;

  elevator_goal_scheduler #(.FLOORS(3), .FW(2), .DWELL(4)) dut_a (
    .clk(clk), .rst(rst), .floor(fa), .moving(mva), .req(rqa),
    .pending(pa), .gf(ga), .gf_valid(gva), .dir_up(dua), .door_open(dopa)
  );

  elevator_goal_scheduler #(.FLOORS(5), .FW(3), .DWELL(4)) dut_b (
    .clk(clk), .rst(rst), .floor(fb), .moving(mvb), .req(rqb),
    .pending(pb), .gf(gb), .gf_valid(gvb), .dir_up(dub), .door_open(dopb)
  );

  elevator_goal_scheduler #(.FLOORS(8), .FW(3), .DWELL(4)) dut_c (
    .clk(clk), .rst(rst), .floor(fc), .moving(mvc), .req(rqc),
    .pending(pc), .gf(gc), .gf_valid(gvc), .dir_up(duc), .door_open(dopc)
  );

  // {pending[7:0], gf[2:0], gf_valid, dir_up, door_open}
  typedef struct {
    int          cyc;
    int          unit;
    string       name;
    logic [13:0] v;
  } exp_t;

  exp_t sb[$];

`ifdef ELEVATOR_COLLECTIVE_EN
  localparam logic [2:0] C_RETGT = 3'd4;
`else
  localparam logic [2:0] C_RETGT = 3'd6;
`endif

  task automatic expect_at(input int c, input int u, input string nm,
                           input logic [7:0] p, input logic [2:0] g,
                           input logic gv, input logic du, input logic dop);
    exp_t e;
    e.cyc  = c;
    e.unit = u;
    e.name = nm;
    e.v    = {p, g, gv, du, dop};
    sb.push_back(e);
  endtask

  function automatic logic [13:0] actual(input int u);
    unique case (u)
      0:       return {5'b0, pa, 1'b0, ga, gva, dua, dopa};
      1:       return {3'b0, pb, gb, gvb, dub, dopb};
      default: return {pc, gc, gvc, duc, dopc};
    endcase
  endfunction

  always @(negedge clk) begin
    logic [13:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        act = actual(sb[i].unit);
        checks++;
        if (sb[i].cyc < cyc) begin
          errors++;
          $display("FAIL %s: not sampled in cycle %0d", sb[i].name, sb[i].cyc);
        end else if (act !== sb[i].v) begin
          errors++;
          $display("FAIL %s @%0d: got %b want %b (pend,gf,gv,dir,door)",
                   sb[i].name, cyc, act, sb[i].v);
        end
        sb.delete(i);
      end
    end
  end

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    fa = 2'd1; mva = 1'b0; rqa = 3'b111;
    fb = 3'd1; mvb = 1'b0; rqb = '0;
    fc = 3'd2; mvc = 1'b0; rqc = '0;

    go(1);
    rqa = '0;

    go(2);
    rst = 1'b0;
    expect_at(2, 0, "a_reset", 8'h00, 3'd0, 0, 1, 0);
    expect_at(2, 1, "b_reset", 8'h00, 3'd0, 0, 1, 0);
    expect_at(2, 2, "c_reset", 8'h00, 3'd0, 0, 1, 0);
    rqa = 3'b101;
    rqb = 5'b00100;
    rqc = 8'b0100_0000;
    expect_at(3, 0, "a_tie_pend", 8'b101, 3'd0, 0, 1, 0);
    expect_at(4, 0, "a_tie_goal", 8'b101, 3'd0, 1, 0, 0);
    expect_at(4, 1, "b_goal2", 8'b00100, 3'd2, 1, 1, 0);
    expect_at(4, 2, "c_goal6", 8'b0100_0000, 3'd6, 1, 1, 0);

    go(3);
    rqa = '0; rqb = '0; rqc = '0;

    go(4);
    fa = 2'd0;
    rqb = 5'b10001; mvb = 1'b1;
    rqc = 8'b0001_0000; mvc = 1'b1;
    expect_at(5, 0, "a_door_first", 8'b101, 3'd0, 0, 0, 1);
    expect_at(6, 0, "a_door_clr", 8'b100, 3'd0, 0, 0, 1);
    expect_at(5, 2, "c_hold6", 8'b0101_0000, 3'd6, 1, 1, 0);
    expect_at(6, 2, "c_retarget", 8'b0101_0000, C_RETGT, 1, 1, 0);

    go(5);
    rqb = '0; fb = 3'd2; mvb = 1'b0;
    rqc = '0;
    expect_at(6, 1, "b_serve2", 8'b10101, 3'd2, 0, 1, 1);
    expect_at(7, 1, "b_serve2_clr", 8'b10001, 3'd2, 0, 1, 1);

    go(6);
    rqa = 3'b001;
    expect_at(7, 0, "a_req_in_door", 8'b100, 3'd0, 0, 0, 1);

    go(7);
    rqa = '0;
    expect_at(8, 0, "a_door_last", 8'b100, 3'd0, 0, 0, 1);
    expect_at(9, 0, "a_next_up", 8'b100, 3'd2, 1, 1, 0);
    expect_at(9, 1, "b_door_last", 8'b10001, 3'd2, 0, 1, 1);
    expect_at(10, 1, "b_scan_up4", 8'b10001, 3'd4, 1, 1, 0);

    go(9);
    fa = 2'd2;
    expect_at(10, 0, "a_arrive2", 8'b100, 3'd2, 0, 1, 1);
    expect_at(11, 0, "a_clr2", 8'b000, 3'd2, 0, 1, 1);

    go(10);
    fb = 3'd4;
    expect_at(11, 1, "b_serve4", 8'b10001, 3'd4, 0, 1, 1);
    expect_at(12, 1, "b_serve4_clr", 8'b00001, 3'd4, 0, 1, 1);

    go(11);
    rqa = 3'b100;
    expect_at(12, 0, "a_req2_in_door", 8'b000, 3'd2, 0, 1, 1);

    go(12);
    rqa = '0;
    expect_at(13, 0, "a_door4_last", 8'b000, 3'd2, 0, 1, 1);
    expect_at(14, 0, "a_idle", 8'b000, 3'd2, 0, 1, 0);
    expect_at(15, 1, "b_scan_down0", 8'b00001, 3'd0, 1, 0, 0);

    go(14);
    fa = 2'd3;
    rqa = 3'b010;
    expect_at(15, 0, "a_bad_latch", 8'b010, 3'd2, 0, 1, 0);
    expect_at(16, 0, "a_bad_hold1", 8'b010, 3'd2, 0, 1, 0);
    expect_at(17, 0, "a_bad_hold2", 8'b010, 3'd2, 0, 1, 0);

    go(15);
    rqa = '0;

    go(17);
    fa = 2'd0;
    expect_at(18, 0, "a_resume", 8'b010, 3'd1, 1, 1, 0);

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    while (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: never checked (cycle %0d)", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
